// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, reset PC, memory size and queue entry type for the fetch stage
package fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int MEM_WORDS = 16384;

    typedef struct packed {
        logic [DATA_W-1:0] word;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - memory read port and decode handshake bundle of the fetch stage
interface fetch_if #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W
);
    logic              mem_busy;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_ready;

    modport master (
        input  mem_busy, mem_data, instr_ready,
        output mem_read, mem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output mem_busy, mem_data, instr_ready,
        input  mem_read, mem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - prefetch FIFO of {word, pc}; head output holds its last value while empty
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  fetch_entry_t             push_entry,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     entries [DEPTH];
    fetch_entry_t     last_head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = valid ? entries[rd_ptr] : last_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            last_head <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // Remember the current head so an emptied queue keeps presenting it.
            if (valid) begin
                last_head <= entries[rd_ptr];
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    entries[wr_ptr] <= push_entry;
                    wr_ptr          <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(push) - CNT_W'(do_pop);
            end
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - fetch address, memory issue, prefetch queue; FETCH_BOUND_CHECK_EN adds a sticky bound fault
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int DATA_W = fetch_pkg::DATA_W,
    parameter int DEPTH = 2,
`ifdef FETCH_BOUND_CHECK_EN
    parameter int MEM_WORDS = fetch_pkg::MEM_WORDS,
`endif
    parameter logic [ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    fetch_if.master           bus,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              fault
);
    logic [ADDR_W-1:0]      fetch_pc;
    logic [ADDR_W-1:0]      issued_pc;
    logic                   inflight;
    logic                   pop;
    logic                   push;
    logic                   base_ok;
    logic                   issue;
    logic [$clog2(DEPTH):0] count;
    fetch_entry_t           push_entry;
    fetch_entry_t           head;

    assign pop = bus.instr_valid && bus.instr_ready;

    // Credit rule: a slot must be free once the in-flight word lands and this cycle's pop leaves.
    assign base_ok = !reset && !redirect && !bus.mem_busy &&
                     ((int'(count) + int'(inflight) - int'(pop)) < DEPTH);

`ifdef FETCH_BOUND_CHECK_EN
    logic out_of_range;
    assign out_of_range = (32'(fetch_pc) >= 32'(MEM_WORDS));
    assign issue        = base_ok && !fault && !out_of_range;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault <= 1'b0;
        end else if (redirect) begin
            fault <= 1'b0;
        end else if (base_ok && !fault && out_of_range) begin
            fault <= 1'b1;
        end
    end
`else
    assign issue = base_ok;
    assign fault = 1'b0;
`endif

    assign bus.mem_read = issue;
    assign bus.mem_addr = fetch_pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            issued_pc <= '0;
            inflight  <= 1'b0;
        end else if (redirect) begin
            fetch_pc <= redirect_addr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc  <= fetch_pc + 1'b1;
                issued_pc <= fetch_pc;
            end
        end
    end

    // A response landing in a redirect cycle belongs to the abandoned stream.
    assign push       = inflight && !redirect;
    assign push_entry = '{word: DATA_W'(bus.mem_data), pc: issued_pc};

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .valid      (bus.instr_valid),
        .count      (count)
    );

    assign bus.instr    = head.word;
    assign bus.instr_pc = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;
    logic        clk;
    logic        reset;
    logic        redirect;
    logic [15:0] redirect_addr;
    logic        fault;
    int          checks;
    int          errors;

    fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory image: word at address a is a + 16'h1000, returned one cycle after the read.
    always @(posedge clk) begin
        if (reset)
            bus.mem_data <= 16'h0000;
        else if (bus.mem_read)
            bus.mem_data <= bus.mem_addr + 16'h1000;
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic ready);
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        bus.mem_busy  = 1'b0;
        bus.instr_ready = ready;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset         = 1'b1;
        redirect      = 1'b0;
        redirect_addr = 16'h0000;
        bus.mem_busy  = 1'b0;
        bus.instr_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL reset_mem_read got %0h want 0", bus.mem_read); end
        checks++; if (bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr got %0h want 0", bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid got %0h want 0", bus.instr_valid); end
        checks++; if (bus.instr !== 16'h0000) begin errors++; $display("FAIL reset_instr got %0h want 0", bus.instr); end
        checks++; if (bus.instr_pc !== 16'h0000) begin errors++; $display("FAIL reset_instr_pc got %0h want 0", bus.instr_pc); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0h want 0", fault); end
    endtask

    task automatic test_stream;
        apply_reset(1'b1);
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL stream_first_issue got rd=%0h addr=%0h want rd=1 addr=0", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL stream_latency got valid=%0h want 0", bus.instr_valid); end
        next_cycle();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus.instr_valid !== 1'b1 || bus.instr !== 16'h1000 + 16'(k) || bus.instr_pc !== 16'(k)) begin
                errors++;
                $display("FAIL stream_word%0d got v=%0h instr=%0h pc=%0h want v=1 instr=%0h pc=%0h",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, 16'h1000 + 16'(k), k);
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure;
        int issues;
        apply_reset(1'b0);
        issues = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus.mem_read) begin
                checks++;
                if (bus.mem_addr !== 16'(issues)) begin errors++; $display("FAIL bp_issue_addr got %0h want %0h", bus.mem_addr, issues); end
                issues++;
            end
            if (c < 5) next_cycle();
        end
        checks++; if (issues !== 2) begin errors++; $display("FAIL bp_issue_count got %0d want 2", issues); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL bp_full_mem_read got %0h want 0", bus.mem_read); end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000) begin errors++; $display("FAIL bp_full_head got v=%0h pc=%0h want v=1 pc=0", bus.instr_valid, bus.instr_pc); end
        next_cycle();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0002) begin errors++; $display("FAIL bp_release_issue got rd=%0h addr=%0h want rd=1 addr=2", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_pc !== 16'h0001 || bus.instr !== 16'h1001) begin errors++; $display("FAIL bp_second_word got pc=%0h instr=%0h want pc=1 instr=1001", bus.instr_pc, bus.instr); end
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0003) begin errors++; $display("FAIL bp_next_issue got rd=%0h addr=%0h want rd=1 addr=3", bus.mem_read, bus.mem_addr); end
        next_cycle();
    endtask

    task automatic test_redirect;
        apply_reset(1'b0);
        next_cycle();
        next_cycle();
        redirect      = 1'b1;
        redirect_addr = 16'h0040;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL redir_no_issue got %0h want 0", bus.mem_read); end
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_flush_valid got %0h want 0", bus.instr_valid); end
        checks++; if (bus.instr_pc !== 16'h0000) begin errors++; $display("FAIL redir_hold_pc got %0h want 0", bus.instr_pc); end
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0040) begin errors++; $display("FAIL redir_issue got rd=%0h addr=%0h want rd=1 addr=40", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b0) begin errors++; $display("FAIL redir_r2_valid got %0h want 0", bus.instr_valid); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0040 || bus.instr !== 16'h1040) begin errors++; $display("FAIL redir_r3_head got v=%0h pc=%0h instr=%0h want v=1 pc=40 instr=1040", bus.instr_valid, bus.instr_pc, bus.instr); end
        next_cycle();
        bus.instr_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.instr_pc !== 16'h0040) begin errors++; $display("FAIL redir_r4_head got pc=%0h want 40", bus.instr_pc); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0041) begin errors++; $display("FAIL redir_r5_head got v=%0h pc=%0h want v=1 pc=41", bus.instr_valid, bus.instr_pc); end
        next_cycle();
    endtask

    task automatic test_mem_busy;
        int exp_issue;
        int exp_del;
        apply_reset(1'b1);
        exp_issue = 0;
        exp_del   = 0;
        for (int c = 0; c < 16; c++) begin
            bus.mem_busy = (c >= 3 && c <= 5);
            @(negedge clk);
            if (bus.mem_busy) begin
                checks++;
                if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL busy_issue_c%0d got %0h want 0", c, bus.mem_read); end
            end
            if (bus.mem_read) begin
                checks++;
                if (bus.mem_addr !== 16'(exp_issue)) begin errors++; $display("FAIL busy_addr got %0h want %0h", bus.mem_addr, exp_issue); end
                exp_issue++;
            end
            if (bus.instr_valid) begin
                checks++;
                if (bus.instr_pc !== 16'(exp_del) || bus.instr !== 16'h1000 + 16'(exp_del)) begin
                    errors++;
                    $display("FAIL busy_deliver got pc=%0h instr=%0h want pc=%0h instr=%0h", bus.instr_pc, bus.instr, exp_del, 16'h1000 + 16'(exp_del));
                end
                exp_del++;
            end
            next_cycle();
        end
        bus.mem_busy = 1'b0;
        checks++; if (exp_del !== 11) begin errors++; $display("FAIL busy_deliver_count got %0d want 11", exp_del); end
    endtask

    task automatic test_wrap;
        apply_reset(1'b1);
        next_cycle();
        next_cycle();
        redirect = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
        redirect_addr = 16'h3FFF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h3FFF) begin errors++; $display("FAIL bound_issue got rd=%0h addr=%0h want rd=1 addr=3fff", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL bound_block got %0h want 0", bus.mem_read); end
        next_cycle();
        @(negedge clk);
        checks++; if (fault !== 1'b1) begin errors++; $display("FAIL bound_fault got %0h want 1", fault); end
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h3FFF || bus.instr !== 16'h4FFF) begin errors++; $display("FAIL bound_drain got v=%0h pc=%0h instr=%0h want v=1 pc=3fff instr=4fff", bus.instr_valid, bus.instr_pc, bus.instr); end
        checks++; if (bus.mem_read !== 1'b0) begin errors++; $display("FAIL bound_halt got %0h want 0", bus.mem_read); end
        next_cycle();
        redirect      = 1'b1;
        redirect_addr = 16'h0000;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL bound_clear got %0h want 0", fault); end
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL bound_restart got rd=%0h addr=%0h want rd=1 addr=0", bus.mem_read, bus.mem_addr); end
        next_cycle();
`else
        redirect_addr = 16'hFFFF;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'hFFFF) begin errors++; $display("FAIL wrap_issue_ffff got rd=%0h addr=%0h want rd=1 addr=ffff", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL wrap_issue_0 got rd=%0h addr=%0h want rd=1 addr=0", bus.mem_read, bus.mem_addr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'hFFFF || bus.instr !== 16'h0FFF) begin errors++; $display("FAIL wrap_word_ffff got v=%0h pc=%0h instr=%0h want v=1 pc=ffff instr=0fff", bus.instr_valid, bus.instr_pc, bus.instr); end
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr !== 16'h1000) begin errors++; $display("FAIL wrap_word_0 got v=%0h pc=%0h instr=%0h want v=1 pc=0 instr=1000", bus.instr_valid, bus.instr_pc, bus.instr); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got %0h want 0", fault); end
        next_cycle();
`endif
    endtask

    task automatic test_async_reset;
        apply_reset(1'b1);
        repeat (4) next_cycle();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL areset_mem got rd=%0h addr=%0h want rd=0 addr=0", bus.mem_read, bus.mem_addr); end
        checks++; if (bus.instr_valid !== 1'b0 || bus.instr !== 16'h0000 || bus.instr_pc !== 16'h0000) begin errors++; $display("FAIL areset_head got v=%0h instr=%0h pc=%0h want all 0", bus.instr_valid, bus.instr, bus.instr_pc); end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_addr !== 16'h0000) begin errors++; $display("FAIL areset_restart got rd=%0h addr=%0h want rd=1 addr=0", bus.mem_read, bus.mem_addr); end
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 16'h0000 || bus.instr !== 16'h1000) begin errors++; $display("FAIL areset_first_word got v=%0h pc=%0h instr=%0h want v=1 pc=0 instr=1000", bus.instr_valid, bus.instr_pc, bus.instr); end
        next_cycle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_mem_busy();
        test_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
